mem_stage: RTL

//  RV32 memory-access stage. Consumes the EX/MEM pipeline register outputs and

---
 rtl/mem_stage_if.sv | 39 +++
 rtl/mem_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// EX/MEM -> MEM stage -> MEM/WB signal bundle.
// Handshake: there is no valid/ready pair. Every cycle the upstream register
// presents one (possibly empty) access; while stall_mem=1 the upstream must hold
// every EX/MEM field stable, and the access is consumed on the first rising
// edge where stall_mem=0. MEM/WB outputs are registered and change only on edges.
interface mem_stage_if;
    // EX/MEM pipeline register fields
    logic [31:0] alu_mem_in;
    logic [31:0] RD2_mem_in;
    logic [4:0]  A3_mem_in;
    logic        RegWriteM;
    logic [1:0]  MEM_CtrlM;
    logic [2:0]  funct3_mem_in;
    // pipeline control back to earlier stages
    logic        stall_mem;
    // MEM/WB pipeline register fields
    logic [31:0] alu_memwb_out;
    logic [31:0] RD_memwb_out;
    logic [4:0]  A3_memwb_out;
    logic        RegWriteW;
    logic        MemToRegW;
    logic        fault_memwb_out;
    // debug view of the access FSM (1 = BUSY)
    logic        busy_dbg;

    // upstream pipeline / testbench side
    modport master (
        output alu_mem_in, RD2_mem_in, A3_mem_in, RegWriteM, MEM_CtrlM, funct3_mem_in,
        input  stall_mem, alu_memwb_out, RD_memwb_out, A3_memwb_out, RegWriteW,
               MemToRegW, fault_memwb_out, busy_dbg
    );

    // memory stage side
    modport slave (
        input  alu_mem_in, RD2_mem_in, A3_mem_in, RegWriteM, MEM_CtrlM, funct3_mem_in,
        output stall_mem, alu_memwb_out, RD_memwb_out, A3_memwb_out, RegWriteW,
               MemToRegW, fault_memwb_out, busy_dbg
    );
endinterface

// File: rtl/mem_stage.sv
// RV32 memory-access stage: decodes the EX/MEM access, checks it for legality
// and alignment, performs it on an internal word-addressed RAM whose access
// takes LATENCY cycles, stalls the pipeline meanwhile, and registers the
// MEM/WB fields (load data already lane-steered and extended).
module mem_stage #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input logic        clk,
    input logic        rst_n,
    mem_stage_if.slave bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    // BUSY starts with LATENCY-2 remaining stall cycles; the IDLE cycle is the first.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);
    localparam logic             MULTI_CYCLE = (LATENCY > 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        req, mem_read, mem_write, bad;
    logic        legal_f3, misaligned;
    logic        stall;
    logic        ram_we;
    logic [3:0]  byte_en;
    logic [31:0] wr_data;
    logic [31:0] rd_word;
    logic [31:0] load_ext;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [AW-1:0] word_idx;

    logic [31:0] alu_q, alu_d;
    logic [31:0] rd_q, rd_d;
    logic [4:0]  a3_q, a3_d;
    logic        reg_write_q, reg_write_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic        fault_q, fault_d;

    logic [31:0] ram [DEPTH];

    // Upper address bits beyond the RAM size are ignored, so addresses wrap.
    assign word_idx = bus.alu_mem_in[AW+1:2];

    // Access decode: request type, legality of size/sign code and alignment.
    always_comb begin
        req        = |bus.MEM_CtrlM;
        mem_read   = (bus.MEM_CtrlM == 2'b10);
        mem_write  = (bus.MEM_CtrlM == 2'b01);
        legal_f3   = 1'b0;
        if (mem_read) begin
            legal_f3 = bus.funct3_mem_in inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end else if (mem_write) begin
            legal_f3 = bus.funct3_mem_in inside {3'b000, 3'b001, 3'b010};
        end
        misaligned = ((bus.funct3_mem_in[1:0] == 2'b01) && bus.alu_mem_in[0]) ||
                     ((bus.funct3_mem_in[1:0] == 2'b10) && (bus.alu_mem_in[1:0] != 2'b00));
        // MEM_CtrlM=11 is neither a plain read nor write, so legal_f3 stays 0.
        bad        = req && (!legal_f3 || misaligned);
    end

    // Access FSM next state and stall; a bad access never enters BUSY.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req && !bad && MULTI_CYCLE) begin
                    stall   = 1'b1;
                    state_d = S_BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            S_BUSY: begin
                if (cnt_q != '0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Store lane steering: replicate the datum to every lane, enable only the addressed ones.
    always_comb begin
        byte_en = 4'b0000;
        wr_data = bus.RD2_mem_in;
        case (bus.funct3_mem_in[1:0])
            2'b00: begin
                byte_en = 4'b0001 << bus.alu_mem_in[1:0];
                wr_data = {4{bus.RD2_mem_in[7:0]}};
            end
            2'b01: begin
                byte_en = bus.alu_mem_in[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{bus.RD2_mem_in[15:0]}};
            end
            2'b10: begin
                byte_en = 4'b1111;
                wr_data = bus.RD2_mem_in;
            end
            default: begin
                byte_en = 4'b0000;
                wr_data = bus.RD2_mem_in;
            end
        endcase
    end

    // Writes land only on the completing (non-stalled) edge; held off while in reset.
    assign ram_we = rst_n && !stall && mem_write && !bad;

    // Data RAM write port with byte enables; contents are never reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    ram[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Load lane selection and sign/zero extension.
    always_comb begin
        rd_word  = ram[word_idx];
        rd_byte  = rd_word[8*bus.alu_mem_in[1:0] +: 8];
        rd_half  = bus.alu_mem_in[1] ? rd_word[31:16] : rd_word[15:0];
        load_ext = rd_word;
        case (bus.funct3_mem_in)
            3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_ext = {24'h0, rd_byte};
            3'b101:  load_ext = {16'h0, rd_half};
            default: load_ext = rd_word;
        endcase
    end

    // MEM/WB next values: capture on free edges, insert a bubble on stalled edges.
    always_comb begin
        alu_d        = alu_q;
        rd_d         = rd_q;
        a3_d         = a3_q;
        reg_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        fault_d      = 1'b0;
        if (!stall) begin
            alu_d        = bus.alu_mem_in;
            a3_d         = bus.A3_mem_in;
            reg_write_d  = bus.RegWriteM && !bad;
            mem_to_reg_d = mem_read && !bad;
            fault_d      = bad;
            rd_d         = (mem_read && !bad) ? load_ext : 32'h0;
        end
    end

    // MEM/WB pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_q        <= '0;
            rd_q         <= '0;
            a3_q         <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            alu_q        <= alu_d;
            rd_q         <= rd_d;
            a3_q         <= a3_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            fault_q      <= fault_d;
        end
    end

    assign bus.stall_mem       = stall;
    assign bus.alu_memwb_out   = alu_q;
    assign bus.RD_memwb_out    = rd_q;
    assign bus.A3_memwb_out    = a3_q;
    assign bus.RegWriteW       = reg_write_q;
    assign bus.MemToRegW       = mem_to_reg_q;
    assign bus.fault_memwb_out = fault_q;
    assign bus.busy_dbg        = (state_q == S_BUSY);
endmodule
